// File: rtl/pattern_gen_pkg.sv
// Shared encodings and helpers for the multi-channel test-pattern generator.
package pattern_gen_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned GRAY_W = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_RAMP    = 3'd0,
    MODE_CONST   = 3'd1,
    MODE_ONES    = 3'd2,
    MODE_ZEROS   = 3'd3,
    MODE_COUNT   = 3'd4,
    MODE_CHECKER = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  // Binary to reflected Gray; callers zero-extend narrower values and truncate the result.
  function automatic logic [GRAY_W-1:0] gray(input logic [GRAY_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/pattern_gen_mc_if.sv
// Configuration/timing inputs and pixel outputs of the pattern generator.
interface pattern_gen_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NCH    = 2,
  parameter int unsigned STEP_W = 4
);
  logic                   f_sync;
  logic                   sync;
  logic [2:0]             mode;
  logic [DATA_W-1:0]      const_val;
  logic [STEP_W-1:0]      dx;
  logic [STEP_W-1:0]      dy;
  logic [STEP_W-1:0]      ch_step;
  logic                   gray_en;
  logic [NCH*DATA_W-1:0]  dout;
  logic                   valid;
  logic                   eol;
  logic                   eof;
  logic                   busy;

  modport master (
    output f_sync, sync, mode, const_val, dx, dy, ch_step, gray_en,
    input  dout, valid, eol, eof, busy
  );

  modport slave (
    input  f_sync, sync, mode, const_val, dx, dy, ch_step, gray_en,
    output dout, valid, eol, eof, busy
  );
endinterface

// File: rtl/pattern_timing.sv
// Frame/line sequencer: pixel and line counters plus the IDLE/WAIT_LINE/ACTIVE FSM.
module pattern_timing
  import pattern_gen_pkg::*;
#(
  parameter int unsigned LINE_LEN = 4096,
  parameter int unsigned LINES    = 32,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned LINE_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_sync,
  input  logic              sync,
  output logic              active_c,
  output logic [PIX_W-1:0]  pix,
  output logic [LINE_W-1:0] line,
  output logic              eol_c,
  output logic              eof_c,
  output logic              busy
);

  state_t state;

  // A pixel is produced on the sync edge itself so it is visible one cycle later.
  always_comb begin
    active_c = 1'b0;
    eol_c    = 1'b0;
    eof_c    = 1'b0;
    if (!f_sync) begin
      active_c = (state == ST_ACTIVE) || ((state == ST_WAIT_LINE) && sync);
    end
    eol_c = active_c && (pix == PIX_W'(LINE_LEN - 1));
    eof_c = eol_c && (line == LINE_W'(LINES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pix   <= '0;
      line  <= '0;
      busy  <= 1'b0;
    end else begin
      // Held high through the eof cycle, low the cycle after.
      busy <= f_sync || (state != ST_IDLE);
      if (f_sync) begin
        state <= ST_WAIT_LINE;
        pix   <= '0;
        line  <= '0;
      end else if (active_c) begin
        if (eol_c) begin
          pix <= '0;
          if (eof_c) begin
            state <= ST_IDLE;
            line  <= '0;
          end else begin
            state <= ST_WAIT_LINE;
            line  <= line + LINE_W'(1);
          end
        end else begin
          state <= ST_ACTIVE;
          pix   <= pix + PIX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pattern_gen_mc.sv
// Multi-channel test-pattern generator: per-pixel value datapath, channel offsets, output registers.
module pattern_gen_mc
  import pattern_gen_pkg::*;
#(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned LINE_LEN = 4096,
  parameter int unsigned LINES    = 32,
  parameter int unsigned NCH      = 2,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned CHK_SH   = 3
) (
  input  logic          clk,
  input  logic          rst,
  pattern_gen_if.slave  bus
);

  localparam int unsigned PIX_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned OUT_W  = NCH * DATA_W;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] const_val;
    logic [STEP_W-1:0] dx;
    logic [STEP_W-1:0] dy;
    logic [STEP_W-1:0] ch_step;
    logic              gray_en;
  } cfg_t;

  cfg_t              cfg;
  logic              active_c, eol_c, eof_c, busy_q;
  logic [PIX_W-1:0]  pix;
  logic [LINE_W-1:0] line;

  logic [DATA_W-1:0] lbase, ramp_acc, cnt;
  logic [DATA_W-1:0] ramp_v, base_v, ch_v, off;
  logic              chk_c;
  logic [OUT_W-1:0]  dout_c;

  logic [OUT_W-1:0]  dout_q;
  logic              valid_q, eol_q, eof_q;

  pattern_timing #(
    .LINE_LEN (LINE_LEN),
    .LINES    (LINES),
    .PIX_W    (PIX_W),
    .LINE_W   (LINE_W)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .f_sync   (bus.f_sync),
    .sync     (bus.sync),
    .active_c (active_c),
    .pix      (pix),
    .line     (line),
    .eol_c    (eol_c),
    .eof_c    (eof_c),
    .busy     (busy_q)
  );

  // Value of the pixel being produced this edge, then per-channel offset and optional Gray.
  always_comb begin
    base_v = '0;
    dout_c = '0;
    ch_v   = '0;
    off    = '0;
    ramp_v = (pix == '0) ? lbase : ramp_acc;
    chk_c  = (|((pix >> CHK_SH) & PIX_W'(1))) ^ (|((line >> CHK_SH) & LINE_W'(1)));
    case (cfg.mode)
      MODE_RAMP:    base_v = ramp_v;
      MODE_CONST:   base_v = cfg.const_val;
      MODE_ONES:    base_v = '1;
      MODE_COUNT:   base_v = cnt;
      MODE_CHECKER: base_v = chk_c ? '1 : '0;
      default:      base_v = '0;
    endcase
    for (int k = 0; k < NCH; k++) begin
      ch_v = base_v + off;
      if (cfg.gray_en) begin
        ch_v = DATA_W'(gray(GRAY_W'(ch_v)));
      end
      dout_c[k*DATA_W +: DATA_W] = ch_v;
      off = off + DATA_W'(cfg.ch_step);
    end
  end

  // Config latch, ramp/count accumulators and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg      <= '0;
      lbase    <= '0;
      ramp_acc <= '0;
      cnt      <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      valid_q <= active_c;
      eol_q   <= eol_c;
      eof_q   <= eof_c;
      if (bus.f_sync) begin
        cfg <= '{mode:      bus.mode,
                 const_val: bus.const_val,
                 dx:        bus.dx,
                 dy:        bus.dy,
                 ch_step:   bus.ch_step,
                 gray_en:   bus.gray_en};
        lbase    <= '0;
        ramp_acc <= '0;
        cnt      <= '0;
      end else if (active_c) begin
        dout_q   <= dout_c;
        cnt      <= cnt + DATA_W'(1);
        ramp_acc <= ramp_v + DATA_W'(cfg.dx);
        if (eol_c) begin
          lbase <= lbase + DATA_W'(cfg.dy);
        end
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.eol   = eol_q;
  assign bus.eof   = eof_q;
  assign bus.busy  = busy_q;

endmodule
